// File: rtl/dsr_right_pipe_n_s_if.sv
// ----------------------------------------------------------------------------
// dsr_right_pipe_n_s_if
//
// Purpose : Bundles the streaming handshake and payload signals of the
//           pipelined right shifter into one interface, so the shifter and
//           its environment connect through a single port.
//
// Signals :
//   in_valid   upstream item present
//   in_ready   shifter accepts the upstream item this cycle
//   in_data    operand to shift (N bits)
//   in_shift   logical right-shift amount (S bits)
//   in_tag     sideband tag carried with the item (W_TAG bits)
//   out_valid  downstream item present
//   out_ready  downstream accepts the item
//   out_data   in_data >> in_shift, zero-filled
//   out_sticky OR of every bit shifted out
//   out_tag    in_tag of the same item
//
// Modports:
//   master  the environment: drives the upstream payload and out_ready
//   slave   the shifter: drives in_ready and the downstream payload
// ----------------------------------------------------------------------------
interface dsr_right_pipe_n_s_if #(
    parameter int N     = 16,
    parameter int S     = 4,
    parameter int W_TAG = 8
);

    logic             in_valid;
    logic             in_ready;
    logic [N-1:0]     in_data;
    logic [S-1:0]     in_shift;
    logic [W_TAG-1:0] in_tag;

    logic             out_valid;
    logic             out_ready;
    logic [N-1:0]     out_data;
    logic             out_sticky;
    logic [W_TAG-1:0] out_tag;

    modport master (
        output in_valid,
        output in_data,
        output in_shift,
        output in_tag,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  out_sticky,
        input  out_tag
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  in_shift,
        input  in_tag,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output out_sticky,
        output out_tag
    );

endinterface

// File: rtl/dsr_right_pipe_n_s.sv
// ----------------------------------------------------------------------------
// dsr_right_pipe_n_s
//
// Purpose : Pipelined logarithmic right shifter with sticky-bit capture for
//           posit datapaths (mantissa alignment, fraction extraction).
//           Stage k consumes shift bit k: when that bit is set it shifts the
//           data right by 2^k (zero fill) and ORs the discarded bits into
//           sticky. A tag word rides along with every item untouched.
//           The whole pipe advances on a single enable
//           adv = !out_valid || out_ready, so a stall freezes every stage
//           and bubbles are never collapsed.
//
// Parameters:
//   N      data width (N >= 2)
//   S      shift-amount width; number of register stages
//   W_TAG  sideband tag width
//
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   bus    dsr_right_pipe_n_s_if.slave: in_valid/in_ready/in_data/in_shift/
//          in_tag upstream, out_valid/out_ready/out_data/out_sticky/out_tag
//          downstream
//
// Latency : an item accepted at edge t is presented on the outputs after
//           edge t+S-1 when the pipe is not stalled.
// ----------------------------------------------------------------------------
module dsr_right_pipe_n_s #(
    parameter int N     = 16,
    parameter int S     = 4,
    parameter int W_TAG = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    dsr_right_pipe_n_s_if.slave   bus
);

    // Mask selecting the low min(n, N) bits of a data word.
    function automatic logic [N-1:0] low_mask(input int unsigned n);
        logic [N-1:0] m;
        for (int unsigned i = 0; i < N; i++) begin
            m[i] = (i < n);
        end
        return m;
    endfunction

    // Global pipeline enable shared by every stage.
    logic w_adv;

    genvar k;
    for (k = 0; k < S; k++) begin : g_stage

        // Shift distance handled by this stage and the bits it can discard.
        // Once 2^k reaches N the mask covers the whole word and the shifted
        // value is all zeros, which gives the overshift behaviour for free.
        localparam int unsigned   SH        = 1 << k;
        localparam logic [N-1:0]  DROP_MASK = low_mask(SH);

        // Stage input: the unconsumed shift bits are [S-1:k] of the original
        // amount, so bit 0 of w_in_shamt is the bit this stage acts on.
        logic             w_in_valid;
        logic [N-1:0]     w_in_data;
        logic [S-1-k:0]   w_in_shamt;
        logic             w_in_sticky;
        logic [W_TAG-1:0] w_in_tag;

        logic [N-1:0]     w_shifted;
        logic             w_dropped;

        logic             r_valid;
        logic [N-1:0]     r_data;
        logic             r_sticky;
        logic [W_TAG-1:0] r_tag;

        if (k == 0) begin : g_src
            assign w_in_valid  = bus.in_valid;
            assign w_in_data   = bus.in_data;
            assign w_in_shamt  = bus.in_shift;
            assign w_in_sticky = 1'b0;
            assign w_in_tag    = bus.in_tag;
        end else begin : g_src
            assign w_in_valid  = g_stage[k-1].r_valid;
            assign w_in_data   = g_stage[k-1].r_data;
            assign w_in_shamt  = g_stage[k-1].g_sh.r_shamt;
            assign w_in_sticky = g_stage[k-1].r_sticky;
            assign w_in_tag    = g_stage[k-1].r_tag;
        end

        assign w_shifted = w_in_data >> SH;
        assign w_dropped = |(w_in_data & DROP_MASK);

        // NOTE: Sequential state uses non-blocking assignments so every stage
        // samples its predecessor's pre-edge value; blocking here would let an
        // item race through several stages in one clock.
        // NOTE: Payload registers are reset as well as the valid bits so the
        // outputs read as zero straight after reset, not just invalid.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                r_valid  <= 1'b0;
                r_data   <= '0;
                r_sticky <= 1'b0;
                r_tag    <= '0;
            end else if (w_adv) begin
                r_valid  <= w_in_valid;
                r_data   <= w_in_shamt[0] ? w_shifted : w_in_data;
                r_sticky <= w_in_sticky | (w_in_shamt[0] & w_dropped);
                r_tag    <= w_in_tag;
            end
        end

        // Remaining shift bits for later stages; the last stage has none.
        if (k < S - 1) begin : g_sh
            logic [S-2-k:0] r_shamt;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_shamt <= '0;
                end else if (w_adv) begin
                    r_shamt <= w_in_shamt[S-1-k:1];
                end
            end
        end
    end

    // The pipe may move whenever the output slot is empty or being drained.
    // in_ready never looks at in_valid.
    assign w_adv        = !g_stage[S-1].r_valid || bus.out_ready;
    assign bus.in_ready = w_adv;

    assign bus.out_valid  = g_stage[S-1].r_valid;
    assign bus.out_data   = g_stage[S-1].r_data;
    assign bus.out_sticky = g_stage[S-1].r_sticky;
    assign bus.out_tag    = g_stage[S-1].r_tag;

endmodule

// File: tb/tb_dsr_right_pipe_n_s.sv
// ----------------------------------------------------------------------------
// tb_dsr_right_pipe_n_s
//
// Self-checking bench for dsr_right_pipe_n_s. A 16-bit instance carries the
// main tests; an 8-bit instance covers shifts beyond the data width.
// Inputs are driven mid low phase, outputs sampled one unit later, both well
// away from the rising edge.
// ----------------------------------------------------------------------------
module tb_dsr_right_pipe_n_s;

    localparam int N  = 16;
    localparam int S  = 4;
    localparam int WT = 8;
    localparam int N8 = 8;

    logic clk;
    logic rst_n;

    dsr_right_pipe_n_s_if #(.N(N),  .S(S), .W_TAG(WT)) bus ();
    dsr_right_pipe_n_s_if #(.N(N8), .S(S), .W_TAG(WT)) b8  ();

    dsr_right_pipe_n_s #(.N(N), .S(S), .W_TAG(WT)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    dsr_right_pipe_n_s #(.N(N8), .S(S), .W_TAG(WT)) u_dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ------------------------------------------------------------------
    // Scoreboard and reference model
    // ------------------------------------------------------------------
    typedef struct {
        logic [N-1:0]  data;
        logic          sticky;
        logic [WT-1:0] tag;
    } item_t;

    typedef struct {
        logic [N-1:0] data;
        logic [S-1:0] shift;
        logic [N-1:0] exp_data;
        logic         exp_sticky;
    } vec_t;

    typedef struct {
        logic [N8-1:0] data;
        logic          sticky;
    } item8_t;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int n_out    = 0;

    item_t  exp_q[$];
    int     got_tags[$];
    int     got_cyc[$];
    item8_t got8[$];

    logic          last_in_xfer;
    logic          stall_prev;
    logic [N-1:0]  prev_data;
    logic          prev_sticky;
    logic [WT-1:0] prev_tag;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Division by 2^s gives the shifted value; the remainder is exactly the
    // discarded bits, so sticky is "remainder non-zero".
    function automatic item_t ref_model(input logic [N-1:0] d, input logic [S-1:0] s,
                                        input logic [WT-1:0] t);
        item_t       r;
        int unsigned dv;
        int unsigned dvs;
        dv       = d;
        dvs      = 32'd1 << s;
        r.data   = N'(dv / dvs);
        r.sticky = (dv % dvs) != 0;
        r.tag    = t;
        return r;
    endfunction

    // One clock: sample the settled pre-edge state, update the model, then
    // advance to the next mid-low-phase point.
    task automatic cycle();
        item_t e;
        #1;
        cyc++;
        last_in_xfer = 1'b0;
        if (!rst_n) begin
            exp_q.delete();
            stall_prev = 1'b0;
        end else begin
            check("in_ready_rule", bus.in_ready, !bus.out_valid || bus.out_ready);
            if (stall_prev) begin
                check("stall_valid",  bus.out_valid,  1'b1);
                check("stall_data",   bus.out_data,   prev_data);
                check("stall_sticky", bus.out_sticky, prev_sticky);
                check("stall_tag",    bus.out_tag,    prev_tag);
            end
            if (bus.in_valid && bus.in_ready) begin
                exp_q.push_back(ref_model(bus.in_data, bus.in_shift, bus.in_tag));
                last_in_xfer = 1'b1;
            end
            if (bus.out_valid && bus.out_ready) begin
                check("model_has_item", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("out_data",   bus.out_data,   e.data);
                    check("out_sticky", bus.out_sticky, e.sticky);
                    check("out_tag",    bus.out_tag,    e.tag);
                end
                got_tags.push_back(int'(bus.out_tag));
                got_cyc.push_back(cyc);
                n_out++;
            end
            stall_prev  = bus.out_valid && !bus.out_ready;
            prev_data   = bus.out_data;
            prev_sticky = bus.out_sticky;
            prev_tag    = bus.out_tag;
            if (b8.out_valid && b8.out_ready) begin
                got8.push_back('{data: b8.out_data, sticky: b8.out_sticky});
            end
        end
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [N-1:0] d, input logic [S-1:0] s,
                         input logic [WT-1:0] t);
        bus.in_valid = v;
        bus.in_data  = d;
        bus.in_shift = s;
        bus.in_tag   = t;
    endtask

    // Wait for out_valid, counting clocks since acceptance (already one).
    task automatic wait_out(output int n);
        n = 1;
        while (!bus.out_valid && n < 12) begin
            cycle();
            n++;
        end
    endtask

    vec_t vecs[7];

    initial begin
        int n;
        int sent;
        int out_base;

        vecs[0] = '{data: 16'hF000, shift: 4'd4,  exp_data: 16'h0F00, exp_sticky: 1'b0};
        vecs[1] = '{data: 16'h8001, shift: 4'd1,  exp_data: 16'h4000, exp_sticky: 1'b1};
        vecs[2] = '{data: 16'h8001, shift: 4'd15, exp_data: 16'h0001, exp_sticky: 1'b1};
        vecs[3] = '{data: 16'h1234, shift: 4'd0,  exp_data: 16'h1234, exp_sticky: 1'b0};
        vecs[4] = '{data: 16'hFFFF, shift: 4'd8,  exp_data: 16'h00FF, exp_sticky: 1'b1};
        vecs[5] = '{data: 16'h0100, shift: 4'd8,  exp_data: 16'h0001, exp_sticky: 1'b0};
        vecs[6] = '{data: 16'h00F0, shift: 4'd5,  exp_data: 16'h0007, exp_sticky: 1'b1};

        stall_prev    = 1'b0;
        prev_data     = '0;
        prev_sticky   = 1'b0;
        prev_tag      = '0;
        rst_n         = 1'b0;
        drive(1'b0, '0, '0, '0);
        bus.out_ready = 1'b1;
        b8.in_valid   = 1'b0;
        b8.in_data    = '0;
        b8.in_shift   = '0;
        b8.in_tag     = '0;
        b8.out_ready  = 1'b1;

        @(negedge clk);
        #1;
        cycle();
        cycle();
        rst_n = 1'b1;

        // Reset state
        check("rst_out_valid",  bus.out_valid,  1'b0);
        check("rst_out_data",   bus.out_data,   16'h0);
        check("rst_out_sticky", bus.out_sticky, 1'b0);
        check("rst_out_tag",    bus.out_tag,    8'h0);
        check("rst_in_ready",   bus.in_ready,   1'b1);

        // Table-driven single items with latency check
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, vecs[i].data, vecs[i].shift, WT'(i));
            cycle();
            drive(1'b0, '0, '0, '0);
            wait_out(n);
            check("vec_latency", n,              S);
            check("vec_data",    bus.out_data,   vecs[i].exp_data);
            check("vec_sticky",  bus.out_sticky, vecs[i].exp_sticky);
            check("vec_tag",     bus.out_tag,    WT'(i));
            cycle();
        end

        // Exhaustive shift sweep, back to back
        got_tags.delete();
        got_cyc.delete();
        for (int s = 0; s < 16; s++) begin
            drive(1'b1, 16'hA5A5, S'(s), WT'(s));
            cycle();
        end
        drive(1'b0, '0, '0, '0);
        for (int i = 0; i < 8; i++) cycle();
        check("sweep_count", got_tags.size(), 16);
        if (got_tags.size() == 16) begin
            for (int i = 0; i < 16; i++) check("sweep_tag_order", got_tags[i], i);
            check("sweep_back_to_back", got_cyc[15] - got_cyc[0], 15);
        end

        // Backpressure with random stimulus, including a 5-cycle hold
        out_base = n_out;
        sent     = 0;
        for (int c = 0; c < 800 && (sent < 20 || exp_q.size() != 0); c++) begin
            if (c >= 6 && c < 11) bus.out_ready = 1'b0;
            else                  bus.out_ready = ($urandom_range(0, 2) != 0);
            if (sent < 20 && $urandom_range(0, 3) != 0)
                drive(1'b1, N'($urandom), S'($urandom), WT'(sent));
            else
                drive(1'b0, N'($urandom), S'($urandom), WT'($urandom));
            cycle();
            if (last_in_xfer) sent++;
        end
        drive(1'b0, '0, '0, '0);
        bus.out_ready = 1'b1;
        check("bp_items_out",   n_out - out_base, 20);
        check("bp_model_empty", exp_q.size(),     0);

        // Overshift on the 8-bit instance
        got8.delete();
        b8.in_valid = 1'b1; b8.in_data = 8'h01; b8.in_shift = 4'd12; b8.in_tag = 8'd1;
        cycle();
        b8.in_data = 8'h00; b8.in_shift = 4'd15; b8.in_tag = 8'd2;
        cycle();
        b8.in_data = 8'hFF; b8.in_shift = 4'd7;  b8.in_tag = 8'd3;
        cycle();
        b8.in_valid = 1'b0;
        for (int i = 0; i < 6; i++) cycle();
        check("ovs_count", got8.size(), 3);
        if (got8.size() == 3) begin
            check("ovs_12_data",   got8[0].data,   8'h00);
            check("ovs_12_sticky", got8[0].sticky, 1'b1);
            check("ovs_15_data",   got8[1].data,   8'h00);
            check("ovs_15_sticky", got8[1].sticky, 1'b0);
            check("ovs_7_data",    got8[2].data,   8'h01);
            check("ovs_7_sticky",  got8[2].sticky, 1'b1);
        end

        // Reset mid-flight: three items in the pipe are discarded
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, N'($urandom) | 16'h8000, S'(i), WT'(8'hE0 + i));
            cycle();
        end
        drive(1'b0, '0, '0, '0);
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        check("mid_rst_out_valid",  bus.out_valid,  1'b0);
        check("mid_rst_out_data",   bus.out_data,   16'h0);
        check("mid_rst_out_sticky", bus.out_sticky, 1'b0);
        check("mid_rst_out_tag",    bus.out_tag,    8'h0);
        check("mid_rst_in_ready",   bus.in_ready,   1'b1);
        drive(1'b1, 16'hC003, 4'd2, 8'h5A);
        cycle();
        drive(1'b0, '0, '0, '0);
        wait_out(n);
        check("post_rst_latency", n,              S);
        check("post_rst_data",    bus.out_data,   16'h3000);
        check("post_rst_sticky",  bus.out_sticky, 1'b1);
        check("post_rst_tag",     bus.out_tag,    8'h5A);
        out_base = n_out;
        for (int i = 0; i < 8; i++) cycle();
        check("post_rst_single_out", n_out - out_base, 1);
        check("post_rst_model_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
